// File: rtl/wb_mtimer.sv
// wb_mtimer: RISC-V machine timer on a Wishbone B3 classic slave.
// Holds a 64-bit mtime counter advanced by a programmable prescaler and a
// 64-bit mtimecmp compare register, and drives a registered level timer
// interrupt (irq = mtime >= mtimecmp) straight into the CPU.
//
// Ports:
//   wb_clk    in   1   system clock, rising edge
//   wb_rst    in   1   synchronous active-high reset
//   wb_adr_i  in  32   byte address, only [4:2] decoded
//   wb_dat_i  in  32   write data
//   wb_sel_i  in   4   byte enables
//   wb_we_i   in   1   write enable
//   wb_cyc_i  in   1   bus cycle
//   wb_stb_i  in   1   strobe
//   wb_cti_i  in   3   ignored (classic cycles only)
//   wb_bte_i  in   2   ignored
//   wb_dat_o  out 32   read data, valid while ack=1, 0 otherwise
//   wb_ack_o  out  1   one-cycle acknowledge
//   wb_err_o  out  1   tied 0
//   wb_rty_o  out  1   tied 0
//   irq       out  1   machine timer interrupt, level, registered
//
// Register map (adr[4:2]):
//   0 MTIME_LO  1 MTIME_HI  2 MTIMECMP_LO  3 MTIMECMP_HI
//   4 PRESCALE  5 CTRL (bit0 enable)  6-7 unmapped (read 0, writes ignored)

module wb_mtimer #(
    parameter logic [31:0] PRESCALE_RST = 32'd49,
    parameter logic        ENABLE_RST   = 1'b1
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        irq
);

    localparam int unsigned DW = 32;
    localparam int unsigned TW = 64;
    localparam int unsigned AW = 3;

    localparam logic [AW-1:0] A_MTIME_LO    = 3'd0;
    localparam logic [AW-1:0] A_MTIME_HI    = 3'd1;
    localparam logic [AW-1:0] A_MTIMECMP_LO = 3'd2;
    localparam logic [AW-1:0] A_MTIMECMP_HI = 3'd3;
    localparam logic [AW-1:0] A_PRESCALE    = 3'd4;
    localparam logic [AW-1:0] A_CTRL        = 3'd5;

    // Architectural state
    logic [TW-1:0] r_mtime;
    logic [TW-1:0] r_mtimecmp;
    logic [DW-1:0] r_prescale;
    logic [DW-1:0] r_pcnt;
    logic          r_enable;
    logic [DW-1:0] r_hi_snap;

    // Bus-side registers
    logic          r_ack;
    logic [DW-1:0] r_dat;
    logic          r_irq;

    // Decode and datapath wires
    logic [AW-1:0] w_addr;
    logic          w_req;
    logic          w_wr;
    logic          w_rd;
    logic          w_any_sel;
    logic [DW-1:0] w_wmask;
    logic          w_wr_mtime_lo;
    logic          w_wr_mtime_hi;
    logic          w_wr_cmp_lo;
    logic          w_wr_cmp_hi;
    logic          w_wr_prescale;
    logic          w_wr_ctrl;
    logic          w_tick;
    logic [DW:0]   w_lo_sum;
    logic          w_lo_carry;
    logic [DW-1:0] w_hi_inc;
    logic [DW-1:0] w_mtime_lo_nxt;
    logic [DW-1:0] w_mtime_hi_nxt;
    logic [DW-1:0] w_pcnt_nxt;
    logic [DW-1:0] w_rdata;

    // Burst/extension signals and the undecoded address bits are not used.
    logic w_unused;
    assign w_unused = &{1'b0, wb_cti_i, wb_bte_i, wb_adr_i[31:5], wb_adr_i[1:0]};

    // Replace only the byte lanes selected by mask.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [DW-1:0] mask);
        f_merge = (old_v & ~mask) | (new_v & mask);
    endfunction

    // Request qualification: a new access is taken only while ack is low.
    assign w_addr    = wb_adr_i[4:2];
    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr      = w_req & wb_we_i;
    assign w_rd      = w_req & ~wb_we_i;
    assign w_any_sel = |wb_sel_i;
    assign w_wmask   = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                        {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    // Per-register write strobes.
    always_comb begin
        w_wr_mtime_lo = 1'b0;
        w_wr_mtime_hi = 1'b0;
        w_wr_cmp_lo   = 1'b0;
        w_wr_cmp_hi   = 1'b0;
        w_wr_prescale = 1'b0;
        w_wr_ctrl     = 1'b0;
        if (w_wr) begin
            case (w_addr)
                A_MTIME_LO:    w_wr_mtime_lo = 1'b1;
                A_MTIME_HI:    w_wr_mtime_hi = 1'b1;
                A_MTIMECMP_LO: w_wr_cmp_lo   = 1'b1;
                A_MTIMECMP_HI: w_wr_cmp_hi   = 1'b1;
                A_PRESCALE:    w_wr_prescale = 1'b1;
                A_CTRL:        w_wr_ctrl     = 1'b1;
                default:       ;
            endcase
        end
    end

    // Prescaler: tick on the edge where the counter matches PRESCALE.
    assign w_tick = r_enable & (r_pcnt == r_prescale);

    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (w_wr_prescale && w_any_sel) begin
            w_pcnt_nxt = '0;
        end else if (r_enable) begin
            w_pcnt_nxt = w_tick ? '0 : r_pcnt + DW'(1);
        end
    end

    // mtime increment with write collision: written bytes win, unwritten
    // bytes take the incremented value, and a LO write kills the carry.
    always_comb begin
        w_lo_sum       = {1'b0, r_mtime[DW-1:0]} + (DW+1)'(w_tick);
        w_lo_carry     = w_lo_sum[DW] & ~w_wr_mtime_lo;
        w_hi_inc       = r_mtime[TW-1:DW] + DW'(w_lo_carry);
        w_mtime_lo_nxt = w_lo_sum[DW-1:0];
        w_mtime_hi_nxt = w_hi_inc;
        if (w_wr_mtime_lo) begin
            w_mtime_lo_nxt = f_merge(w_lo_sum[DW-1:0], wb_dat_i, w_wmask);
        end
        if (w_wr_mtime_hi) begin
            w_mtime_hi_nxt = f_merge(w_hi_inc, wb_dat_i, w_wmask);
        end
    end

    // Read mux; MTIME_HI returns the snapshot taken by the last LO read.
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_MTIME_LO:    w_rdata = r_mtime[DW-1:0];
            A_MTIME_HI:    w_rdata = r_hi_snap;
            A_MTIMECMP_LO: w_rdata = r_mtimecmp[DW-1:0];
            A_MTIMECMP_HI: w_rdata = r_mtimecmp[TW-1:DW];
            A_PRESCALE:    w_rdata = r_prescale;
            A_CTRL:        w_rdata = {{(DW-1){1'b0}}, r_enable};
            default:       w_rdata = '0;
        endcase
    end

    // Bus handshake and read data; data is zero whenever ack is low.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_hi_snap <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : '0;
            if (w_rd && (w_addr == A_MTIME_LO)) begin
                r_hi_snap <= r_mtime[TW-1:DW];
            end
        end
    end

    // Timer state: mtime, prescaler and programmable registers.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_prescale <= PRESCALE_RST;
            r_pcnt     <= '0;
            r_enable   <= ENABLE_RST;
        end else begin
            r_mtime <= {w_mtime_hi_nxt, w_mtime_lo_nxt};
            r_pcnt  <= w_pcnt_nxt;
            if (w_wr_cmp_lo) begin
                r_mtimecmp[DW-1:0] <= f_merge(r_mtimecmp[DW-1:0], wb_dat_i, w_wmask);
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp[TW-1:DW] <= f_merge(r_mtimecmp[TW-1:DW], wb_dat_i, w_wmask);
            end
            if (w_wr_prescale) begin
                r_prescale <= f_merge(r_prescale, wb_dat_i, w_wmask);
            end
            if (w_wr_ctrl && wb_sel_i[0]) begin
                r_enable <= wb_dat_i[0];
            end
        end
    end

    // Interrupt compares current register values, independent of enable.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign wb_dat_o = r_dat;
    assign wb_ack_o = r_ack;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;
    assign irq      = r_irq;

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed bench for wb_mtimer: register access, prescaler timing, atomic
// 64-bit reads, interrupt timing, byte lanes, freeze and reset behaviour.
module tb_wb_mtimer;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    int unsigned edge_cnt = 0;
    logic        irq_at_ack;

    localparam logic [31:0] A_LO   = 32'h00;
    localparam logic [31:0] A_HI   = 32'h04;
    localparam logic [31:0] A_CLO  = 32'h08;
    localparam logic [31:0] A_CHI  = 32'h0C;
    localparam logic [31:0] A_PRE  = 32'h10;
    localparam logic [31:0] A_CTRL = 32'h14;

    wb_mtimer dut (
        .wb_clk   (clk),
        .wb_rst   (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One classic cycle; returns read data and the edge index of the ack.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int unsigned e);
        int n;
        @(negedge clk);
        adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b1 && n < 8);
        chk("ack_latency", 64'(n), 64'd1);
        rd = dat_o;
        e = edge_cnt;
        irq_at_ack = irq;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = '0;
        @(posedge clk); #1;
        chk("ack_width", 64'(ack), 64'd0);
        chk("dat_idle", 64'(dat_o), 64'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int unsigned e);
        logic [31:0] dummy;
        xfer(a, 1'b1, d, s, dummy, e);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v, output int unsigned e);
        xfer(a, 1'b0, 32'h0, 4'hF, v, e);
    endtask

    task automatic check_reset_regs();
        logic [31:0] v;
        int unsigned e;
        rd(A_LO, v, e);   chk("rst_mtime_lo", 64'(v), 64'h0);
        rd(A_HI, v, e);   chk("rst_mtime_hi", 64'(v), 64'h0);
        rd(A_CLO, v, e);  chk("rst_cmp_lo", 64'(v), 64'hFFFF_FFFF);
        rd(A_CHI, v, e);  chk("rst_cmp_hi", 64'(v), 64'hFFFF_FFFF);
        rd(A_PRE, v, e);  chk("rst_prescale", 64'(v), 64'd49);
        rd(A_CTRL, v, e); chk("rst_ctrl", 64'(v), 64'd1);
        chk("rst_irq", 64'(irq), 64'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] v2;
        logic [63:0] m;
        logic [31:0] mc;
        int unsigned e, e2, ew, ew3, ec, ed, ewc;

        rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_irq0", 64'(irq), 64'd0);
        chk("err_rty", 64'({err, rty}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check_reset_regs();

        // PRESCALE=0: one tick per cycle after the write ack
        wr(A_PRE, 32'd0, 4'hF, ew);
        repeat (10) @(posedge clk);
        rd(A_LO, v, e);
        chk("pre0_count", 64'(v), 64'(e - 1 - ew));

        // PRESCALE=3: one tick per 4 cycles (tick also lands on the write edge)
        wr(A_PRE, 32'd3, 4'hF, ew3);
        rd(A_LO, v, e);
        chk("pre3_a", 64'(v), 64'((ew3 - ew) + (e - 1 - ew3) / 4));
        repeat (9) @(posedge clk);
        rd(A_LO, v2, e2);
        chk("pre3_b", 64'(v2), 64'((ew3 - ew) + (e2 - 1 - ew3) / 4));

        // LO wrap and atomic HI snapshot
        wr(A_CTRL, 32'd0, 4'hF, e);
        wr(A_HI, 32'd0, 4'hF, e);
        wr(A_LO, 32'hFFFF_FFFE, 4'hF, e);
        wr(A_PRE, 32'd0, 4'hF, e);
        wr(A_CTRL, 32'd1, 4'hF, ec);
        rd(A_LO, v, e);
        m = 64'hFFFF_FFFE + 64'(e - 1 - ec);
        chk("wrap_lo_a", 64'(v), 64'(m[31:0]));
        rd(A_HI, v, e2);
        chk("wrap_hi_snap_a", 64'(v), 64'(m[63:32]));
        rd(A_LO, v, e);
        m = 64'hFFFF_FFFE + 64'(e - 1 - ec);
        chk("wrap_lo_b", 64'(v), 64'(m[31:0]));
        rd(A_HI, v, e2);
        chk("wrap_hi_snap_b", 64'(v), 64'(m[63:32]));
        chk("wrap_hi_is_1", 64'(v), 64'd1);

        // irq rises one cycle after mtime reaches mtimecmp
        wr(A_CTRL, 32'd0, 4'hF, e);
        wr(A_LO, 32'd0, 4'hF, e);
        wr(A_HI, 32'd0, 4'hF, e);
        wr(A_CHI, 32'd0, 4'hF, e);
        wr(A_CLO, 32'd100, 4'hF, e);
        wr(A_CTRL, 32'd1, 4'hF, ec);
        chk("irq_low_start", 64'(irq), 64'd0);
        repeat (ec + 100 - edge_cnt) @(posedge clk);
        #1;
        chk("irq_before", 64'(irq), 64'd0);
        @(posedge clk); #1;
        chk("irq_rise", 64'(irq), 64'd1);
        wr(A_CLO, 32'hFFFF_FFFF, 4'hF, ew);
        chk("irq_at_cmp_write", 64'(irq_at_ack), 64'd1);
        chk("irq_drop", 64'(irq), 64'd0);

        // Byte lanes and unmapped addresses
        wr(A_CLO, 32'h1234_5678, 4'hF, e);
        wr(A_CLO, 32'hAABB_CCDD, 4'b0100, e);
        rd(A_CLO, v, e);
        chk("byte_lane2", 64'(v), 64'h12BB_5678);
        wr(A_CLO, 32'hFFFF_FFFF, 4'b0000, e);
        rd(A_CLO, v, e);
        chk("sel_none", 64'(v), 64'h12BB_5678);
        wr(32'h18, 32'hDEAD_BEEF, 4'hF, e);
        rd(32'h18, v, e);
        chk("unmapped6", 64'(v), 64'h0);
        rd(32'h1C, v, e);
        chk("unmapped7", 64'(v), 64'h0);

        // Byte write to MTIME_LO on a tick edge, then freeze
        wr(A_LO, 32'h0000_0010, 4'b0001, ewc);
        mc = (32'(ewc - 1 - ec) + 32'd1) & 32'hFFFF_FF00;
        mc = mc | 32'h10;
        wr(A_CTRL, 32'd0, 4'hF, ed);
        rd(A_LO, v, e);
        chk("freeze_a", 64'(v), 64'(mc + 32'(ed - ewc)));
        repeat (50) @(posedge clk);
        rd(A_LO, v, e);
        chk("freeze_b", 64'(v), 64'(mc + 32'(ed - ewc)));
        rd(A_HI, v, e);
        chk("freeze_hi", 64'(v), 64'h0);

        // Reset asserted during a write's ack cycle
        @(negedge clk);
        adr = A_PRE; we = 1'b1; dat_i = 32'd7; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("mid_ack", 64'(ack), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ack", 64'(ack), 64'd0);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check_reset_regs();

        // Reset on the same edge as a request discards the write
        @(negedge clk);
        rst = 1'b1;
        adr = A_CHI; we = 1'b1; dat_i = 32'h55; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ack", 64'(ack), 64'd0);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rd(A_CHI, v, e);
        chk("rst_req_discard", 64'(v), 64'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_mtimer.md
Name: wb_mtimer

Overview:
- RISC-V machine timer peripheral: a Wishbone B3 classic slave on the 32-bit system intercon, placed next to uart0 and gpio0.
- Holds a 64-bit mtime counter driven by a programmable prescaler, plus a 64-bit mtimecmp compare register.
- Drives a registered level timer interrupt directly into the CPU's timerInterrupt input.
- Provides the tick source the boot ROM and RTOS need for delays and scheduling.

Parameters:
- PRESCALE_RST, 49: reset value of the PRESCALE register. mtime ticks every PRESCALE+1 wb_clk cycles, so the default is 1 MHz at 50 MHz.
- ENABLE_RST, 1: reset value of CTRL.enable.

Ports:
- wb_clk  input  1  system clock; all logic is on the rising edge.
- wb_rst  input  1  synchronous, active-high reset.
- wb_adr_i  input  32  byte address. Only [4:2] is decoded.
- wb_dat_i  input  32  write data.
- wb_sel_i  input  4  byte enables; bit n enables dat[8n+7:8n].
- wb_we_i  input  1  write enable.
- wb_cyc_i  input  1  bus cycle.
- wb_stb_i  input  1  strobe.
- wb_cti_i  input  3  ignored; all accesses are treated as classic.
- wb_bte_i  input  2  ignored.
- wb_dat_o  output  32  read data.
- wb_ack_o  output  1  acknowledge.
- wb_err_o  output  1  tied 0.
- wb_rty_o  output  1  tied 0.
- irq  output  1  timer interrupt, level, registered.

Behaviour:
- Clock and reset: one clock, wb_clk. Reset wb_rst is synchronous and active-high.
- Reset values:
  - mtime = 0.
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF.
  - PRESCALE = PRESCALE_RST; prescale counter = 0.
  - CTRL.enable = ENABLE_RST.
  - hi_snap = 0.
  - wb_ack_o = 0, wb_dat_o = 0, irq = 0.
- Register map, decoded on adr[4:2]:
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 PRESCALE (32 bits)
  - 5 CTRL (bit0 enable; other bits read 0)
  - 6–7 unmapped: reads return 0, writes are ignored, ack is still given.
- Handshake:
  - wb_ack_o asserts one cycle after cyc&stb&!wb_ack_o and stays high for exactly one cycle.
  - Back-to-back requests therefore complete every 2 cycles.
  - Write side-effects and the read data capture both happen on the cycle ack is registered.
  - wb_dat_o is valid while ack=1 and is 0 otherwise.
- Byte lanes: writes apply only to bytes whose sel bit is set. sel=0000 acks but changes nothing.
- Prescaler:
  - While enable=1, the counter increments each cycle.
  - When counter == PRESCALE, the counter goes to 0 and mtime increments by 1 (full 64-bit carry) on that same edge.
  - PRESCALE=0 gives an mtime tick every cycle.
  - While enable=0, the counter and mtime hold.
- PRESCALE write: also clears the prescale counter to 0.
- mtime wrap: 64'hFFFF_FFFF_FFFF_FFFF increments to 0; no flag.
- Atomic 64-bit read:
  - Reading MTIME_LO returns mtime[31:0] and, on the same edge, captures mtime[63:32] into hi_snap.
  - Reading MTIME_HI returns hi_snap, not live mtime.
- mtime write/tick collision:
  - A write to MTIME_LO or MTIME_HI in the same cycle as a tick: the written bytes take the written value.
  - Unwritten bytes take the incremented value.
  - The carry from LO into HI is suppressed when MTIME_LO is being written.
- irq:
  - Registered: irq <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on current register values. irq therefore lags the condition by 1 cycle.
  - Does not depend on enable.
  - Cleared only by raising mtimecmp or lowering mtime; there is no clear bit.
- Reset mid-transfer: ack drops to 0 on the reset edge and the write is discarded. The master must restart the cycle.

Test Plan:
- Reset, then read all 6 registers → MTIME_LO/HI = 0/0, MTIMECMP_LO/HI = FFFFFFFF/FFFFFFFF, PRESCALE = 49, CTRL = 1, irq = 0. Each ack is exactly 1 cycle wide.
- Write PRESCALE = 0, let 10 cycles pass, read MTIME_LO → value equals the cycles elapsed since the write ack (±0, checked against a bench model). With PRESCALE = 3, mtime advances exactly 1 per 4 cycles.
- Write MTIME_HI = 0, MTIME_LO = FFFFFFFE with PRESCALE = 0, then read LO then HI → HI = 1 once LO has wrapped. hi_snap matches the HI value at the moment of the LO read, even if a carry occurs between the two reads.
- Write MTIMECMP_HI = 0, MTIMECMP_LO = 100, PRESCALE = 0, mtime = 0 → irq rises exactly 1 cycle after mtime reaches 100. Writing MTIMECMP_LO = FFFFFFFF drops irq 1 cycle after that write's ack.
- Byte write: MTIMECMP_LO = 0x12345678, then write 0xAABBCCDD with sel = 0100 → readback 0x12BB5678. sel = 0000 leaves the value unchanged.
- CTRL = 0 freezes mtime across 50 cycles, with identical reads. Asserting wb_rst during a write's ack cycle → all registers hold reset values and ack = 0 on the next cycle.
